ram_sync_read_dp: RTL and testbench



---
 rtl/ram_sync_read_dp.sv | 96 +++++++++
 tb/tb_ram_sync_read_dp.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_sync_read_dp.sv
// Simple-dual-port sync-read RAM with byte-enable writes, 1- or 2-cycle read latency,
// selectable read-during-write behaviour and a post-reset hardware clear sequence.
module ram_sync_read_dp #(
    parameter int                AWIDTH     = 3,
    parameter int                DWIDTH     = 32,
    parameter int                RD_LATENCY = 1,
    parameter int                RDW_MODE   = 0,
    parameter logic [DWIDTH-1:0] CLR_VALUE  = '0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [AWIDTH-1:0]    wr_addr,
    input  logic [DWIDTH/8-1:0]  wr_be,
    input  logic [DWIDTH-1:0]    din,
    input  logic                 rd_en,
    input  logic [AWIDTH-1:0]    rd_addr,
    output logic [DWIDTH-1:0]    dout,
    output logic                 rd_valid,
    output logic                 busy
);
    localparam int DEPTH   = 1 << AWIDTH;
    localparam int BEWIDTH = DWIDTH / 8;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t              state, state_nxt;
    logic [AWIDTH:0]     clr_addr;
    logic [DWIDTH-1:0]   mem [DEPTH];
    logic                wr_fire, rd_fire;
    logic [DWIDTH-1:0]   rd_word;

    logic [RD_LATENCY-1:0] vld_pipe;
    logic [DWIDTH-1:0]     data_pipe [RD_LATENCY];

    assign busy    = (state == CLEAR);
    assign wr_fire = wr_en && !busy && !reset;
    assign rd_fire = rd_en && !busy && !reset;

    always_comb begin
        state_nxt = state;
        if (state == CLEAR && clr_addr == (AWIDTH+1)'(DEPTH-1))
            state_nxt = RUN;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= CLEAR;
            clr_addr <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR)
                clr_addr <= clr_addr + (AWIDTH+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == CLEAR) begin
                mem[clr_addr[AWIDTH-1:0]] <= CLR_VALUE;
            end else if (wr_en) begin
                for (int i = 0; i < BEWIDTH; i++)
                    if (wr_be[i])
                        mem[wr_addr][8*i +: 8] <= din[8*i +: 8];
            end
        end
    end

    // Array read returns pre-edge contents (read-first); write-through merges din bytes in.
    always_comb begin
        rd_word = mem[rd_addr];
        if (RDW_MODE == 1 && wr_fire && wr_addr == rd_addr) begin
            for (int i = 0; i < BEWIDTH; i++)
                if (wr_be[i])
                    rd_word[8*i +: 8] = din[8*i +: 8];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_pipe <= '0;
            for (int k = 0; k < RD_LATENCY; k++)
                data_pipe[k] <= '0;
        end else begin
            vld_pipe <= RD_LATENCY'({vld_pipe, rd_fire});
            if (rd_fire)
                data_pipe[0] <= rd_word;
            for (int k = 1; k < RD_LATENCY; k++)
                if (vld_pipe[k-1])
                    data_pipe[k] <= data_pipe[k-1];
        end
    end

    assign rd_valid = vld_pipe[RD_LATENCY-1];
    assign dout     = data_pipe[RD_LATENCY-1];
endmodule

// File: tb/tb_ram_sync_read_dp.sv
// Scoreboard bench: two RAM instances (latency 1 / read-first, latency 2 / write-through)
// share one stimulus stream; each has its own expected queue and monitor.
module tb_ram_sync_read_dp;
    logic        clock = 0;
    logic        reset;
    logic        wr_en, rd_en;
    logic [2:0]  wr_addr, rd_addr;
    logic [3:0]  wr_be;
    logic [31:0] din;
    logic [31:0] dout_a, dout_b;
    logic        rd_valid_a, rd_valid_b, busy_a, busy_b;

    int n_vec = 0, n_err = 0, cyc_cnt = 0;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t qa[$], qb[$];
    exp_t ea, eb;

    always #5 clock = ~clock;
    always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

    ram_sync_read_dp #(.AWIDTH(3), .DWIDTH(32), .RD_LATENCY(1), .RDW_MODE(0),
                       .CLR_VALUE(32'hDEADBEEF)) dut_a (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .din(din), .rd_en(rd_en), .rd_addr(rd_addr), .dout(dout_a),
        .rd_valid(rd_valid_a), .busy(busy_a));

    ram_sync_read_dp #(.AWIDTH(3), .DWIDTH(32), .RD_LATENCY(2), .RDW_MODE(1),
                       .CLR_VALUE(32'hDEADBEEF)) dut_b (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .din(din), .rd_en(rd_en), .rd_addr(rd_addr), .dout(dout_b),
        .rd_valid(rd_valid_b), .busy(busy_b));

    always @(negedge clock) begin
        if (rd_valid_a) begin
            n_vec++;
            if (qa.size() == 0) begin
                n_err++;
                $display("FAIL a_unexpected_valid got dout=%h at cycle %0d, required no valid", dout_a, cyc_cnt);
            end else begin
                ea = qa.pop_front();
                if (dout_a !== ea.data || cyc_cnt != ea.cyc) begin
                    n_err++;
                    $display("FAIL a_read got %h at cycle %0d, required %h at cycle %0d",
                             dout_a, cyc_cnt, ea.data, ea.cyc);
                end
            end
        end
        if (rd_valid_b) begin
            n_vec++;
            if (qb.size() == 0) begin
                n_err++;
                $display("FAIL b_unexpected_valid got dout=%h at cycle %0d, required no valid", dout_b, cyc_cnt);
            end else begin
                eb = qb.pop_front();
                if (dout_b !== eb.data || cyc_cnt != eb.cyc) begin
                    n_err++;
                    $display("FAIL b_read got %h at cycle %0d, required %h at cycle %0d",
                             dout_b, cyc_cnt, eb.data, eb.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h required %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        wr_en = 0;
        rd_en = 0;
        wr_be = '0;
    endtask

    task automatic wr_set(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1; wr_addr = a; din = d; wr_be = be;
    endtask

    task automatic write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_set(a, d, be);
        step();
        idle();
    endtask

    // Issues one read for the coming edge; caller deasserts rd_en when the burst ends.
    task automatic rd(input logic [2:0] a, input logic [31:0] da, input logic [31:0] db,
                      input bit pa = 1, input bit pb = 1);
        exp_t e;
        rd_en = 1; rd_addr = a;
        if (pa) begin e.data = da; e.cyc = cyc_cnt + 1; qa.push_back(e); end
        if (pb) begin e.data = db; e.cyc = cyc_cnt + 2; qb.push_back(e); end
        step();
    endtask

    // Call right after releasing reset; counts busy cycles on each instance.
    task automatic count_busy(input string tag);
        int na = 0, nb = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (busy_a) na++;
            if (busy_b) nb++;
            if (!busy_a && !busy_b) break;
        end
        chk({tag, "_busy_a"}, na, 8);
        chk({tag, "_busy_b"}, nb, 8);
    endtask

    task automatic wait_clear();
        for (int k = 0; k < 40 && (busy_a || busy_b); k++) step();
        chk("clear_done", {31'b0, busy_a | busy_b}, 0);
    endtask

    initial begin
        reset = 1; idle(); wr_addr = 0; rd_addr = 0; din = 0;
        step(); step();
        chk("rst_busy_a", {31'b0, busy_a}, 1);
        chk("rst_busy_b", {31'b0, busy_b}, 1);
        chk("rst_vld_a", {31'b0, rd_valid_a}, 0);
        chk("rst_vld_b", {31'b0, rd_valid_b}, 0);
        chk("rst_dout_a", dout_a, 0);
        chk("rst_dout_b", dout_b, 0);

        reset = 0;
        count_busy("clr");
        for (int i = 0; i < 8; i++) rd(3'(i), 32'hDEADBEEF, 32'hDEADBEEF);
        idle();

        write(5, 32'h11223344, 4'hF);
        write(5, 32'hAABBCCDD, 4'b0101);
        rd(5, 32'h11BB33DD, 32'h11BB33DD);
        idle();

        write(0, 10, 4'hF);
        write(1, 11, 4'hF);
        write(2, 12, 4'hF);
        rd(0, 10, 10);
        rd(1, 11, 11);
        rd(2, 12, 12);
        idle();

        write(3, 32'h0, 4'hF);
        wr_set(3, 32'hFFFF0000, 4'hC);
        rd(3, 32'h0, 32'hFFFF0000);
        idle();
        rd(3, 32'hFFFF0000, 32'hFFFF0000);
        // Write to one address while reading another in the same cycle.
        wr_set(6, 32'h5A5A5A5A, 4'hF);
        rd(5, 32'h11BB33DD, 32'h11BB33DD);
        idle();
        rd(6, 32'h5A5A5A5A, 32'h5A5A5A5A);
        idle();
        repeat (4) step();

        // Requests during clear must be dropped.
        reset = 1; step(); reset = 0;
        wr_set(2, 32'h12345678, 4'hF);
        rd_en = 1; rd_addr = 2;
        repeat (4) step();
        idle();
        wait_clear();
        rd(2, 32'hDEADBEEF, 32'hDEADBEEF);
        idle();
        repeat (4) step();

        // Reset at clear step 4.
        reset = 1; step(); reset = 0;
        repeat (4) step();
        reset = 1; step(); reset = 0;
        count_busy("midclr");

        // Reset one cycle after a read issues: latency-2 read must be dropped.
        rd(0, 32'hDEADBEEF, 32'h0, 1, 0);
        rd_en = 0; reset = 1;
        step();
        chk("rrd_dout_a", dout_a, 0);
        chk("rrd_dout_b", dout_b, 0);
        chk("rrd_vld_b", {31'b0, rd_valid_b}, 0);
        reset = 0;
        count_busy("rrd");
        rd(7, 32'hDEADBEEF, 32'hDEADBEEF);
        idle();

        repeat (5) step();
        chk("drain_a", qa.size(), 0);
        chk("drain_b", qb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
